// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO shift sequencer.
// PISO_PARITY_EN adds one even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

`ifdef PISO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable frame bit counter; wraps to zero when it advances past TC_VAL.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int CNT_W  = clog2(DEFAULT_WIDTH + 1),
  parameter int TC_VAL = DEFAULT_WIDTH - 1
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] TC_CNT = CNT_W'(TC_VAL);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/piso_shift_sequencer.sv
// Parallel-in/serial-out sequencer with valid/ready load and downstream stall.
// PISO_PARITY_EN appends the even parity of the captured word as a final bit.
//
// state | meaning
// IDLE  | no frame, load_ready high
// SHIFT | frame bit on sout, advances on shift_en
module piso_shift_sequencer
  import piso_pkg::*;
#(
  parameter int  WIDTH     = DEFAULT_WIDTH,
  parameter bit  LSB_FIRST = 1'b0,
  localparam int FRAME_LEN = WIDTH + PAR_BITS,
  localparam int CNT_W     = clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cnt_tc;
  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] sreg_shifted;

`ifdef PISO_PARITY_EN
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);
  logic par_q, par_d;
`endif

  // A load on the last-bit cycle starts the next frame with no bubble.
  assign last_bit   = (state_q == SHIFT) & cnt_tc & shift_en;
  assign load_ready = (state_q == IDLE) | last_bit;
  assign accept     = load_valid & load_ready;

  assign first_bit    = LSB_FIRST ? load_data[0] : load_data[WIDTH-1];
  assign next_bit     = LSB_FIRST ? sreg_q[1]    : sreg_q[WIDTH-2];
  assign sreg_shifted = LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]}
                                  : {sreg_q[WIDTH-2:0], 1'b0};

  piso_bit_counter #(
    .CNT_W  (CNT_W),
    .TC_VAL (FRAME_LEN - 1)
  ) u_bit_counter (
    .clk_i      (clk),
    .clr_i      (rst),
    .load_i     (accept),
    .load_val_i (CNT_W'(0)),
    .en_i       ((state_q == SHIFT) && shift_en),
    .cnt_o      (bit_cnt),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    sout_d  = sout_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      SHIFT: begin
        if (shift_en) begin
          if (cnt_tc) begin
            done_d  = 1'b1;
            state_d = IDLE;
            sout_d  = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            sreg_d = sreg_shifted;
            sout_d = next_bit;
`ifdef PISO_PARITY_EN
            if (bit_cnt == LAST_DATA) sout_d = par_q;
`endif
          end
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d = SHIFT;
      sreg_d  = load_data;
      sout_d  = first_bit;
      valid_d = 1'b1;
      busy_d  = 1'b1;
`ifdef PISO_PARITY_EN
      par_d   = ^load_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_shift_sequencer.sv
// Directed bench for piso_shift_sequencer, MSB-first and LSB-first instances.
module tb_piso_shift_sequencer;

`ifdef PISO_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int CW = $clog2(NB + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          load_valid = 1'b0, shift_en = 1'b0;
  logic [3:0]    load_data = '0;
  logic          load_ready, sout, sout_valid, busy, done;
  logic [CW-1:0] bit_cnt;

  logic          l_load_valid = 1'b0, l_shift_en = 1'b0;
  logic [3:0]    l_load_data = '0;
  logic          l_load_ready, l_sout, l_sout_valid, l_busy, l_done;
  logic [CW-1:0] l_bit_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Expected serial streams; the fifth entry is the parity bit.
  logic e_1011_msb [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic e_1011_lsb [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic e_0110_msb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  piso_shift_sequencer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .shift_en(shift_en), .sout(sout),
    .sout_valid(sout_valid), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  piso_shift_sequencer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(l_load_valid), .load_ready(l_load_ready),
    .load_data(l_load_data), .shift_en(l_shift_en), .sout(l_sout),
    .sout_valid(l_sout_valid), .busy(l_busy), .done(l_done), .bit_cnt(l_bit_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; shift_en = 1'b1; l_shift_en = 1'b1;
    tick(); tick();
    chk_cnt++;
    if ({sout, sout_valid, busy, done} !== 4'b0000 || bit_cnt !== CW'(0))
      $display("FAIL reset_outputs: got sout/valid/busy/done=%b cnt=%0d want 0000 cnt=0",
               {sout, sout_valid, busy, done}, bit_cnt);
    else pass_cnt++;
    rst = 1'b0;
    tick(); tick();
    chk_cnt++;
    if (load_ready !== 1'b1 || l_load_ready !== 1'b1)
      $display("FAIL reset_load_ready: got %b/%b want 1/1", load_ready, l_load_ready);
    else pass_cnt++;
    chk_cnt++;
    if (bit_cnt !== CW'(0) || sout_valid !== 1'b0)
      $display("FAIL idle_shift_en: got cnt=%0d valid=%b want 0/0", bit_cnt, sout_valid);
    else pass_cnt++;
  endtask

  task automatic test_msb_frame();
    load_data = 4'b1011; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      chk_cnt++;
      if (sout !== e_1011_msb[i] || bit_cnt !== CW'(i) || {sout_valid, busy, done} !== 3'b110)
        $display("FAIL msb_bit%0d: got sout=%b cnt=%0d v/b/d=%b want sout=%b cnt=%0d v/b/d=110",
                 i, sout, bit_cnt, {sout_valid, busy, done}, e_1011_msb[i], i);
      else pass_cnt++;
      chk_cnt++;
      if (load_ready !== (i == NB - 1))
        $display("FAIL msb_ready%0d: got %b want %b", i, load_ready, (i == NB - 1));
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if ({sout, sout_valid, busy, done, load_ready} !== 5'b00011 || bit_cnt !== CW'(0))
      $display("FAIL msb_done: got s/v/b/d/r=%b cnt=%0d want 00011 cnt=0",
               {sout, sout_valid, busy, done, load_ready}, bit_cnt);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL msb_done_pulse: got %b want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_lsb_frame();
    l_load_data = 4'b1011; l_load_valid = 1'b1; l_shift_en = 1'b1;
    tick();
    l_load_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      chk_cnt++;
      if (l_sout !== e_1011_lsb[i] || l_bit_cnt !== CW'(i) || l_sout_valid !== 1'b1)
        $display("FAIL lsb_bit%0d: got sout=%b cnt=%0d valid=%b want sout=%b cnt=%0d valid=1",
                 i, l_sout, l_bit_cnt, l_sout_valid, e_1011_lsb[i], i);
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if ({l_done, l_busy, l_sout_valid} !== 3'b100)
      $display("FAIL lsb_done: got d/b/v=%b want 100", {l_done, l_busy, l_sout_valid});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_stall();
    int cyc;
    load_data = 4'b0110; load_valid = 1'b1; shift_en = 1'b1;
    tick(); cyc = 1;
    load_valid = 1'b0;
    tick(); cyc++;
    shift_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); cyc++;
      chk_cnt++;
      if (sout !== 1'b1 || bit_cnt !== CW'(1) || {sout_valid, done, load_ready} !== 3'b100)
        $display("FAIL stall_hold%0d: got sout=%b cnt=%0d v/d/r=%b want sout=1 cnt=1 v/d/r=100",
                 k, sout, bit_cnt, {sout_valid, done, load_ready});
      else pass_cnt++;
    end
    shift_en = 1'b1;
    for (int i = 1; i < NB; i++) begin
      chk_cnt++;
      if (sout !== e_0110_msb[i] || bit_cnt !== CW'(i))
        $display("FAIL stall_bit%0d: got sout=%b cnt=%0d want sout=%b cnt=%0d",
                 i, sout, bit_cnt, e_0110_msb[i], i);
      else pass_cnt++;
      tick(); cyc++;
    end
    chk_cnt++;
    if (done !== 1'b1 || cyc !== NB + 4)
      $display("FAIL stall_done: got done=%b at cycle %0d want done=1 at cycle %0d", done, cyc, NB + 4);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    load_data = 4'b1011; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    load_data = 4'b0110;
    for (int i = 0; i < NB; i++) begin
      chk_cnt++;
      if (sout !== e_1011_msb[i] || sout_valid !== 1'b1 || load_ready !== (i == NB - 1))
        $display("FAIL b2b_first%0d: got sout=%b valid=%b ready=%b want sout=%b valid=1 ready=%b",
                 i, sout, sout_valid, load_ready, e_1011_msb[i], (i == NB - 1));
      else pass_cnt++;
      tick();
    end
    load_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      chk_cnt++;
      if (sout !== e_0110_msb[i] || bit_cnt !== CW'(i) || sout_valid !== 1'b1 ||
          busy !== 1'b1 || done !== (i == 0))
        $display("FAIL b2b_second%0d: got sout=%b cnt=%0d v/b/d=%b want sout=%b cnt=%0d v/b/d=11%b",
                 i, sout, bit_cnt, {sout_valid, busy, done}, e_0110_msb[i], i, (i == 0));
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if ({done, sout_valid} !== 2'b10)
      $display("FAIL b2b_done: got d/v=%b want 10", {done, sout_valid});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int seen_done;
    load_data = 4'b1011; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_cnt++;
    if ({sout, sout_valid, busy, done} !== 4'b0000 || bit_cnt !== CW'(0))
      $display("FAIL midrst_outputs: got s/v/b/d=%b cnt=%0d want 0000 cnt=0",
               {sout, sout_valid, busy, done}, bit_cnt);
    else pass_cnt++;
    rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < NB + 2; k++) begin
      tick();
      if (done !== 1'b0 || sout_valid !== 1'b0) seen_done++;
    end
    chk_cnt++;
    if (seen_done !== 0)
      $display("FAIL midrst_no_done: got %0d cycles with done/valid set want 0", seen_done);
    else pass_cnt++;
    chk_cnt++;
    if (load_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", load_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_msb_frame();
    test_lsb_frame();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/piso_shift_sequencer.md
Name: piso_shift_sequencer

Overview:
Parallel-in/serial-out shift sequencer. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per cycle on a serial output. Sits directly upstream of the 2:1 multiplexer stage, which consumes the serial bit stream as its data or select input. A small FSM and bit counter track frame progress; a downstream stall input holds the current bit.

Parameters:
WIDTH, 4, bits per frame (minimum 2)
LSB_FIRST, 0, 0 = MSB shifted out first; 1 = LSB first

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
load_valid  input  1  upstream word available
load_ready  output  1  block can accept a word this cycle
load_data  input  WIDTH  word to serialise
shift_en  input  1  downstream accepts current bit this cycle
sout  output  1  current serial bit
sout_valid  output  1  sout holds a frame bit
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the last bit of a frame is accepted
bit_cnt  output  $clog2(WIDTH+1)  bits already accepted in the current frame

Behaviour:
- Single clock (clk); reset is synchronous and active-high (rst).
- Reset values (registered outputs, next edge with rst=1): sout=0, sout_valid=0, busy=0, done=0, bit_cnt=0, state=IDLE. After reset, load_ready=1.
- States: IDLE, SHIFT.
- IDLE: load_ready=1. On load_valid & load_ready, capture load_data into the shift register; next cycle state=SHIFT, sout_valid=1, busy=1, bit_cnt=0, sout=first bit (MSB, or LSB if LSB_FIRST=1).
- SHIFT, shift_en=1:
  - Current bit is accepted and bit_cnt increments.
  - The register shifts, and the next bit appears on sout the following cycle.
- SHIFT, shift_en=0: sout, bit_cnt and the shift register hold (stall of any length).
- Last bit (bit_cnt==WIDTH-1, shift_en=1): next cycle done=1 for exactly one cycle and bit_cnt=0.
  - No pending load: state=IDLE, sout_valid=0, busy=0, sout=0.
- load_ready = (state==IDLE) | (state==SHIFT & bit_cnt==WIDTH-1 & shift_en). This is combinational and allows back-to-back frames.
- Back-to-back: if a load is accepted on the last-bit cycle, the next cycle has done=1 and state=SHIFT with the new word's first bit valid. There is no bubble.
- load_valid in SHIFT outside the last-bit cycle is ignored; the upstream holds it, since load_ready=0.
- Latency: load accept to first bit valid = 1 cycle. A frame with no stalls occupies WIDTH cycles of sout_valid.
- Reset mid-frame: the frame is discarded, no done pulse is issued, and all outputs take their reset values on the next edge.
- rst has priority over load and shift in the same cycle.
- shift_en in IDLE has no effect.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined: after the WIDTH data bits, one extra bit equal to the even parity (XOR) of the captured word is emitted. A frame is WIDTH+1 bits; last-bit, done and load_ready conditions use bit_cnt==WIDTH, and the counter width covers WIDTH+1.
- Undefined: no parity bit and a frame is WIDTH bits; no parity logic is present in the netlist.

Decomposition:
- Shared package piso_pkg:
  - state encoding (IDLE=1'b0, SHIFT=1'b1)
  - default WIDTH constant
  - counter-width function clog2
- One natural sub-module, piso_bit_counter:
  - loadable up-counter with clear, enable and a terminal-count flag
  - terminal count is WIDTH-1, or WIDTH with parity
- The shift register, FSM and handshake stay in the top module.

Test Plan:
- Basic frame, MSB-first: after reset, load 4'b1011 with shift_en=1 throughout -> sout=1,0,1,1 on cycles 1-4 after accept, done=1 on cycle 5, busy=0 and load_ready=1 on cycle 5.
- LSB-first: LSB_FIRST=1, load 4'b1011 -> sout=1,1,0,1, bit_cnt=0,1,2,3.
- Stall: load 4'b0110, deassert shift_en for 3 cycles after the 2nd bit -> sout holds 1, bit_cnt holds 1, and the frame completes with done 3 cycles late.
- Back-to-back: load_valid held high with 4'b1011 then 4'b0110 -> second word's first bit 0 appears the cycle after the last bit of the first frame, done=1 in that same cycle, and sout_valid never drops.
- Reset mid-frame: assert rst after the 2nd bit of 4'b1011 -> next cycle sout=0, sout_valid=0, busy=0, bit_cnt=0, and done never pulses.
- PISO_PARITY_EN defined, load 4'b1011 -> sout=1,0,1,1,1 (parity 1), done after the 5th accepted bit; load 4'b0110 -> parity bit 0.
